// File: rtl/vga_timing_monitor.sv
// Passive VGA timing checker: recovers pixel coordinates from hsync/vsync and reports lock and timing errors.
// Optional macro VGA_TIMING_MONITOR_DE_CHECK_EN adds a comparison of the generator's valid against de_rec.
module vga_timing_monitor #(
  parameter int H_TOTAL     = 800,
  parameter int H_SYNC      = 96,
  parameter int H_BACK      = 48,
  parameter int V_TOTAL     = 525,
  parameter int V_SYNC      = 2,
  parameter int V_BACK      = 33,
  parameter int LOCK_FRAMES = 2,
  parameter int H_ACTIVE    = 640,
  parameter int V_ACTIVE    = 480
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       hsync,
  input  logic       vsync,
  input  logic       valid,
  output logic [9:0] x_rec,
  output logic [9:0] y_rec,
  output logic       de_rec,
  output logic       locked,
  output logic       err_line,
  output logic       err_frame,
  output logic       de_mismatch,
  output logic [7:0] frame_cnt
);

  localparam logic [9:0] L_H_LAST  = 10'(H_TOTAL - 1);
  localparam logic [9:0] L_H_OVER  = 10'(H_TOTAL);
  localparam logic [9:0] L_V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0] L_H_START = 10'(H_SYNC + H_BACK);
  localparam logic [9:0] L_H_END   = 10'(H_SYNC + H_BACK + H_ACTIVE);
  localparam logic [9:0] L_V_START = 10'(V_SYNC + V_BACK);
  localparam logic [9:0] L_V_END   = 10'(V_SYNC + V_BACK + V_ACTIVE);
  localparam logic [7:0] L_LOCK    = 8'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t     r_state;
  logic       r_hs, r_hs_prev, r_vs, r_vs_prev;
  logic [9:0] r_h_cnt, r_v_cnt;
  logic       r_h_armed;
  logic       w_hfall, w_vfall, w_line_err, w_frame_err, w_de;

  assign w_hfall = r_hs_prev & ~r_hs;
  assign w_vfall = r_vs_prev & ~r_vs;

  // Errors are only meaningful once a line reference exists and the monitor is tracking.
  assign w_line_err  = (r_state != SEARCH) && r_h_armed &&
                       (w_hfall ? (r_h_cnt != L_H_LAST) : (r_h_cnt == L_H_OVER));
  assign w_frame_err = (r_state != SEARCH) && w_vfall && (r_v_cnt != L_V_LAST);
  assign w_de        = (r_state == LOCKED) &&
                       (r_h_cnt >= L_H_START) && (r_h_cnt < L_H_END) &&
                       (r_v_cnt >= L_V_START) && (r_v_cnt < L_V_END);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_hs      <= 1'b1;
      r_hs_prev <= 1'b1;
      r_vs      <= 1'b1;
      r_vs_prev <= 1'b1;
      r_h_cnt   <= '0;
      r_v_cnt   <= '0;
    end else begin
      r_hs      <= hsync;
      r_hs_prev <= r_hs;
      r_vs      <= vsync;
      r_vs_prev <= r_vs;
      if (w_hfall)
        r_h_cnt <= '0;
      else if (r_h_cnt != 10'h3FF)
        r_h_cnt <= r_h_cnt + 10'd1;
      if (w_vfall)
        r_v_cnt <= '0;
      else if (w_hfall && (r_v_cnt != 10'h3FF))
        r_v_cnt <= r_v_cnt + 10'd1;
    end
  end

  // Lock FSM; a registered error pulse drops back to SEARCH on the following cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= SEARCH;
      r_h_armed <= 1'b0;
      locked    <= 1'b0;
      frame_cnt <= '0;
      err_line  <= 1'b0;
      err_frame <= 1'b0;
    end else begin
      err_line  <= w_line_err;
      err_frame <= w_frame_err;
      if (w_hfall)
        r_h_armed <= 1'b1;
      case (r_state)
        SEARCH: begin
          if (w_vfall)
            r_state <= ACQUIRE;
        end
        ACQUIRE, LOCKED: begin
          if (err_line || err_frame) begin
            r_state   <= SEARCH;
            r_h_armed <= 1'b0;
            locked    <= 1'b0;
            frame_cnt <= '0;
          end else if (w_vfall && !w_frame_err && !w_line_err) begin
            frame_cnt <= frame_cnt + 8'd1;
            if ((r_state == ACQUIRE) && ((frame_cnt + 8'd1) >= L_LOCK)) begin
              r_state <= LOCKED;
              locked  <= 1'b1;
            end
          end
        end
        default: begin
          r_state <= SEARCH;
          locked  <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_rec <= 1'b0;
      x_rec  <= '0;
      y_rec  <= '0;
    end else begin
      de_rec <= w_de;
      x_rec  <= w_de ? (r_h_cnt - L_H_START) : 10'd0;
      y_rec  <= w_de ? (r_v_cnt - L_V_START) : 10'd0;
    end
  end

`ifdef VGA_TIMING_MONITOR_DE_CHECK_EN
  logic r_valid_d1, r_valid_d2;

  // Two stages of delay line valid up with the counters that produce de_rec.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid_d1  <= 1'b0;
      r_valid_d2  <= 1'b0;
      de_mismatch <= 1'b0;
    end else begin
      r_valid_d1  <= valid;
      r_valid_d2  <= r_valid_d1;
      de_mismatch <= (r_state == LOCKED) && (w_de != r_valid_d2);
    end
  end
`else
  logic w_unused_valid;
  assign w_unused_valid = valid;
  assign de_mismatch    = 1'b0;
`endif

endmodule

// File: tb/tb_vga_timing_monitor.sv
// Directed bench for vga_timing_monitor using a reduced raster so whole frames stay short.
// Expectations for de_mismatch follow VGA_TIMING_MONITOR_DE_CHECK_EN.
module tb_vga_timing_monitor;

  localparam int HT = 20, HS = 2, HB = 3, HA = 12;
  localparam int VT = 12, VS = 1, VB = 2, VA = 7;
  localparam int LOCKF = 2;
  localparam int BIG = 1 << 30;
  localparam int STOP_AT = (VS + VB + 1) * HT + HS + HB + 5;

`ifdef VGA_TIMING_MONITOR_DE_CHECK_EN
  localparam int EXP_MM = 1;
`else
  localparam int EXP_MM = 0;
`endif

  logic       clk = 1'b0, rst = 1'b0;
  logic       hsync = 1'b1, vsync = 1'b1, valid = 1'b0;
  logic [9:0] x_rec, y_rec;
  logic       de_rec, locked, err_line, err_frame, de_mismatch;
  logic [7:0] frame_cnt;

  int checks = 0, errors = 0;
  int cyc = 0;
  int frameStartCyc = 0;

  int errLineCnt = 0, errFrameCnt = 0, errLineCyc = 0;
  int lockRiseCyc = -1, lockFallCyc = -1;
  int deCount = 0, firstSeen = 0, badHold = 0, mmCount = 0;
  int lastX = 0, lastY = 0, mmX = 0, mmY = 0;
  logic prevLocked = 1'b0;

  int baseLine = 0, baseFrame = 0, baseDe = 0, baseFirst = 0, baseMm = 0;

  vga_timing_monitor #(
    .H_TOTAL(HT), .H_SYNC(HS), .H_BACK(HB),
    .V_TOTAL(VT), .V_SYNC(VS), .V_BACK(VB),
    .LOCK_FRAMES(LOCKF), .H_ACTIVE(HA), .V_ACTIVE(VA)
  ) dut (
    .clk(clk), .rst(rst), .hsync(hsync), .vsync(vsync), .valid(valid),
    .x_rec(x_rec), .y_rec(y_rec), .de_rec(de_rec), .locked(locked),
    .err_line(err_line), .err_frame(err_frame), .de_mismatch(de_mismatch),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output observer, sampling on the falling edge while out of reset.
  always @(negedge clk) begin
    if (!rst) begin
      if (err_line) begin
        errLineCnt <= errLineCnt + 1;
        errLineCyc <= cyc;
      end
      if (err_frame) errFrameCnt <= errFrameCnt + 1;
      if (locked && !prevLocked) lockRiseCyc <= cyc;
      if (!locked && prevLocked) lockFallCyc <= cyc;
      prevLocked <= locked;
      if (de_rec) begin
        deCount <= deCount + 1;
        lastX   <= int'(x_rec);
        lastY   <= int'(y_rec);
        if (x_rec == 10'd0 && y_rec == 10'd0) firstSeen <= firstSeen + 1;
      end else if (x_rec != 10'd0 || y_rec != 10'd0) begin
        badHold <= badHold + 1;
      end
      if (de_mismatch) begin
        mmCount <= mmCount + 1;
        mmX     <= int'(x_rec);
        mmY     <= int'(y_rec);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drives one frame of the reduced raster; pixel indices outside [startAt, stopAt) are skipped.
  task automatic applyStimulus(input int nLines, input int shortLine, input int dropX,
                               input int dropY, input int startAt, input int stopAt);
    int idx;
    int len;
    idx = 0;
    for (int l = 0; l < nLines; l++) begin
      len = (l == shortLine) ? HT - 1 : HT;
      for (int p = 0; p < len; p++) begin
        if (idx >= startAt && idx < stopAt) begin
          @(negedge clk);
          if (idx == 0) frameStartCyc = cyc;
          hsync = (p >= HS);
          vsync = (l >= VS);
          valid = (p >= HS + HB) && (p < HS + HB + HA) && (l >= VS + VB) && (l < VS + VB + VA) &&
                  !((p == HS + HB + dropX) && (l == VS + VB + dropY));
        end
        idx++;
      end
    end
    #1;
  endtask

  task automatic snap();
    baseLine  = errLineCnt;
    baseFrame = errFrameCnt;
    baseDe    = deCount;
    baseFirst = firstSeen;
    baseMm    = mmCount;
  endtask

  initial begin
    $display("[TB] start");
    #3 rst = 1'b1;
    #1 checkOutput("reset outputs",
                   64'({x_rec, y_rec, de_rec, locked, err_line, err_frame, de_mismatch, frame_cnt}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    snap();

    // Acquisition from reset: lock lands on the third vsync fall.
    applyStimulus(VT, -1, -1, -1, 0, BIG);
    applyStimulus(VT, -1, -1, -1, 0, BIG);
    checkOutput("acquire locked", 64'(locked), 64'd0);
    checkOutput("acquire frame_cnt", 64'(frame_cnt), 64'd1);
    applyStimulus(VT, -1, -1, -1, 0, BIG);
    checkOutput("lock latency", 64'(lockRiseCyc - frameStartCyc), 64'd2);
    checkOutput("locked after 3 falls", 64'(locked), 64'd1);
    checkOutput("frame_cnt at lock", 64'(frame_cnt), 64'd2);
    checkOutput("no err_line on clean stream", 64'(errLineCnt - baseLine), 64'd0);
    checkOutput("no err_frame on clean stream", 64'(errFrameCnt - baseFrame), 64'd0);

    // Locked frame with valid dropped at active pixel (5,3).
    snap();
    applyStimulus(VT, -1, 5, 3, 0, BIG);
    checkOutput("de_rec count", 64'(deCount - baseDe), 64'(HA * VA));
    checkOutput("first pixel seen", 64'(firstSeen - baseFirst), 64'd1);
    checkOutput("last x_rec", 64'(lastX), 64'(HA - 1));
    checkOutput("last y_rec", 64'(lastY), 64'(VA - 1));
    checkOutput("frame_cnt locked", 64'(frame_cnt), 64'd3);
    checkOutput("de_mismatch pulses", 64'(mmCount - baseMm), 64'(EXP_MM));
`ifdef VGA_TIMING_MONITOR_DE_CHECK_EN
    checkOutput("mismatch x", 64'(mmX), 64'd5);
    checkOutput("mismatch y", 64'(mmY), 64'd3);
`endif

    // One short line while locked, then relock over two good frames.
    snap();
    applyStimulus(VT, 4, -1, -1, 0, BIG);
    checkOutput("short line err_line", 64'(errLineCnt - baseLine), 64'd1);
    checkOutput("unlock delay", 64'(lockFallCyc - errLineCyc), 64'd1);
    checkOutput("unlocked after short line", 64'(locked), 64'd0);
    checkOutput("frame_cnt after short line", 64'(frame_cnt), 64'd0);
    applyStimulus(VT, -1, -1, -1, 0, BIG);
    applyStimulus(VT, -1, -1, -1, 0, BIG);
    checkOutput("relock pending", 64'(locked), 64'd0);
    checkOutput("relock frame_cnt", 64'(frame_cnt), 64'd1);
    applyStimulus(VT, -1, -1, -1, 0, BIG);
    checkOutput("relocked", 64'(locked), 64'd1);
    checkOutput("single err_line", 64'(errLineCnt - baseLine), 64'd1);
    checkOutput("no err_frame on short line", 64'(errFrameCnt - baseFrame), 64'd0);

    // Frame one line short while locked.
    snap();
    applyStimulus(VT - 1, -1, -1, -1, 0, BIG);
    applyStimulus(VT, -1, -1, -1, 0, BIG);
    checkOutput("short frame err_frame", 64'(errFrameCnt - baseFrame), 64'd1);
    checkOutput("short frame no err_line", 64'(errLineCnt - baseLine), 64'd0);
    checkOutput("unlocked after short frame", 64'(locked), 64'd0);
    checkOutput("frame_cnt after short frame", 64'(frame_cnt), 64'd0);
    applyStimulus(VT, -1, -1, -1, 0, BIG);
    checkOutput("search then acquire frame_cnt", 64'(frame_cnt), 64'd0);
    checkOutput("still unlocked", 64'(locked), 64'd0);

    // Relock, then reset in the middle of an active line.
    applyStimulus(VT, -1, -1, -1, 0, BIG);
    applyStimulus(VT, -1, -1, -1, 0, BIG);
    applyStimulus(VT, -1, -1, -1, 0, STOP_AT);
    @(posedge clk);
    #1;
    checkOutput("pre-reset locked", 64'(locked), 64'd1);
    checkOutput("pre-reset de_rec", 64'(de_rec), 64'd1);
    checkOutput("pre-reset x_rec", 64'(x_rec), 64'd2);
    checkOutput("pre-reset y_rec", 64'(y_rec), 64'd1);
    #2 rst = 1'b1;
    #1 checkOutput("mid-line reset outputs",
                   64'({x_rec, y_rec, de_rec, locked, err_line, err_frame, de_mismatch, frame_cnt}), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    snap();
    applyStimulus(VT, -1, -1, -1, STOP_AT, BIG);
    checkOutput("post-reset locked", 64'(locked), 64'd0);
    checkOutput("post-reset no err_line", 64'(errLineCnt - baseLine), 64'd0);
    checkOutput("post-reset no err_frame", 64'(errFrameCnt - baseFrame), 64'd0);
    applyStimulus(VT, -1, -1, -1, 0, BIG);
    applyStimulus(VT, -1, -1, -1, 0, BIG);
    checkOutput("reacquire frame_cnt", 64'(frame_cnt), 64'd1);
    applyStimulus(VT, -1, -1, -1, 0, BIG);
    checkOutput("reacquired locked", 64'(locked), 64'd1);
    checkOutput("reacquire no err_line", 64'(errLineCnt - baseLine), 64'd0);
    checkOutput("reacquire no err_frame", 64'(errFrameCnt - baseFrame), 64'd0);
    checkOutput("coordinates held at 0", 64'(badHold), 64'd0);
    checkOutput("total de_mismatch", 64'(mmCount), 64'(EXP_MM));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
